approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Downstream consumer of the 8-bit approximate multiplier in the accuracy-evaluation path.
- Accepts a stream of (a, b, approximate product) samples over a valid/ready handshake.
- Computes the exact product internally and the error distance ED = |a*b - approx|.
- Over a run of 2^N_LOG2 samples, accumulates error count, ED sum (mean error distance = sum_ed >> N_LOG2) and maximum ED with the operands that produced it.

Parameters:
W, 8, operand width; the product width is 2W.
N_LOG2, 8, log2 of the number of samples per run (default 256).
ACC_W, 2*W+N_LOG2, width of the sum_ed accumulator; sized so it cannot overflow.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset is synchronous and active-high
start  input  1  pulse; begins a new run from IDLE or DONE
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample this cycle
in_a  input  W  multiplicand
in_b  input  W  multiplier
in_prod  input  2W  approximate product for (in_a, in_b)
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE; results are stable
err_count  output  N_LOG2+1  number of samples with ED != 0
sum_ed  output  ACC_W  sum of ED over the run
max_ed  output  2W  largest ED in the run
max_a  output  W  in_a of the first sample reaching max_ed
max_b  output  W  in_b of the first sample reaching max_ed

Behaviour:
- Reset values: all outputs and internal counters are 0; state = IDLE; in_ready = 0; pipeline valid bits cleared.
- Reset mid-run: discards all in-flight samples and partial results immediately; no done pulse.
- States:
  - IDLE: start -> RUN; clears all accumulators and the accepted-sample counter.
  - RUN: in_ready = 1 while accepted < 2^N_LOG2. On the accept that makes accepted = 2^N_LOG2 -> DRAIN (in_ready drops the next cycle).
  - DRAIN: in_ready = 0. Exits to DONE on the edge at which the last sample is accumulated.
  - DONE: done = 1 and outputs hold. start -> RUN, with the same clearing as in IDLE (done drops the next cycle).
- start is ignored in RUN and DRAIN.
- Handshake: accept = in_valid & in_ready. in_valid may toggle freely; bubbles are allowed. Inputs are sampled only on accept. in_ready does not depend combinationally on in_valid.
- Pipeline; accept at edge k:
  - S1 (edge k): registers a, b, prod and a valid bit.
  - S2 (edge k+1): exact = a*b as an unsigned 2W-bit value; ED = exact >= prod ? exact - prod : prod - exact; registers ED, a, b and valid.
  - S3 (edge k+2): accumulates.
  - Fully pipelined: one sample per cycle sustained.
- Accumulate rules:
  - err_count += (ED != 0).
  - sum_ed += ED, zero-extended to ACC_W.
  - If ED > max_ed (strictly greater), update max_ed, max_a and max_b. Ties keep the earliest sample.
  - A sample with ED = 0 leaves max_a and max_b unchanged; they stay 0 if every sample has ED = 0.
- Latency:
  - The last sample is accepted at edge k. Accumulators are final at edge k+2, and DONE is entered at that same edge, so done = 1 and the results are valid from the cycle after edge k+2.
  - With no bubbles, done rises 2^N_LOG2 + 2 cycles after the first accept.
- Results are visible as running values during RUN but are only guaranteed final while done = 1.
- Width rule: err_count can reach 2^N_LOG2, hence N_LOG2+1 bits. max_ed is at most 2^(2W)-1.

Test Plan:
1. Exact stream: start, then 256 samples with in_prod = in_a*in_b (random operands, no bubbles) -> done 258 cycles after the first accept; err_count = 0, sum_ed = 0, max_ed = 0, max_a = max_b = 0.
2. Zero operands through the approximate multiplier (product 16'h0006), 256 samples -> err_count = 256, sum_ed = 1536, max_ed = 6, max_a = max_b = 0.
3. Max and tie: sample 5 = (a=8'hFF, b=8'hFF, prod=16'h0000), so ED = 65025; sample 9 is identical but with a and b swapped; all other samples exact -> max_ed = 65025, max_a = max_b = 8'hFF taken from sample 5; err_count = 2, sum_ed = 130050.
4. Backpressure and bubbles: random in_valid at 30% duty; start pulsed during RUN -> start ignored; exactly 256 samples accepted; in_ready = 0 in DRAIN and DONE; extra valid samples are not counted.
5. Reset mid-run: rst high for one cycle after 100 accepts -> next cycle state is IDLE, all outputs are 0, in_ready = 0; a new start followed by a full run gives correct fresh totals.
6. Back-to-back runs: start in DONE -> accumulators clear and done falls the next cycle; second run results are independent of the first.

Source files
------------

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: accuracy monitor for an approximate W x W multiplier.
// Accepts (a, b, approx product) samples and computes the error distance of each one.
// Over a run of 2^N_LOG2 samples it accumulates the error count, the sum of error
// distances, and the maximum error distance together with the operands that produced it.
module approx_mult_err_monitor #(
    parameter int unsigned W      = 8,
    parameter int unsigned N_LOG2 = 8,
    parameter int unsigned ACC_W  = 2*W + N_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic [2*W-1:0]      in_prod,
    output logic                busy,
    output logic                done,
    output logic [N_LOG2:0]     err_count,
    output logic [ACC_W-1:0]    sum_ed,
    output logic [2*W-1:0]      max_ed,
    output logic [W-1:0]        max_a,
    output logic [W-1:0]        max_b
);

    localparam int unsigned PW      = 2*W;
    localparam int unsigned CNT_W   = N_LOG2 + 1;
    localparam int unsigned RUN_LEN = 2**N_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_accepted;
    logic [CNT_W-1:0]   r_err_count;
    logic [ACC_W-1:0]   r_sum_ed;
    logic [PW-1:0]      r_max_ed;
    logic [W-1:0]       r_max_a;
    logic [W-1:0]       r_max_b;

    // Stage 1: captured sample
    logic               r_s1_valid;
    logic [W-1:0]       r_s1_a;
    logic [W-1:0]       r_s1_b;
    logic [PW-1:0]      r_s1_prod;

    // Stage 2: error distance and its operands
    logic               r_s2_valid;
    logic [PW-1:0]      r_s2_ed;
    logic [W-1:0]       r_s2_a;
    logic [W-1:0]       r_s2_b;

    logic               w_accept;
    logic               w_last_accept;
    logic               w_start_run;
    logic [PW-1:0]      w_exact;
    logic [PW-1:0]      w_ed;
    logic               w_ed_nz;

    assign w_accept      = in_valid & r_in_ready;
    assign w_last_accept = w_accept && (r_accepted == CNT_W'(RUN_LEN - 1));
    assign w_start_run   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_exact       = PW'(r_s1_a) * PW'(r_s1_b);
    assign w_ed          = (w_exact >= r_s1_prod) ? (w_exact - r_s1_prod) : (r_s1_prod - w_exact);
    assign w_ed_nz       = |r_s2_ed;

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err_count;
    assign sum_ed    = r_sum_ed;
    assign max_ed    = r_max_ed;
    assign max_a     = r_max_a;
    assign max_b     = r_max_b;

    // Two-stage datapath: capture on accept, then compute the error distance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_prod  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ed    <= '0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_prod <= in_prod;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ed <= w_ed;
                r_s2_a  <= r_s1_a;
                r_s2_b  <= r_s1_b;
            end
        end
    end

    // Run control FSM and stage-3 accumulation; a new run's clear overrides accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_accepted  <= '0;
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
        end else begin
            if (r_s2_valid) begin
                r_err_count <= r_err_count + CNT_W'(w_ed_nz);
                r_sum_ed    <= r_sum_ed + ACC_W'(r_s2_ed);
                if (r_s2_ed > r_max_ed) begin
                    r_max_ed <= r_s2_ed;
                    r_max_a  <= r_s2_a;
                    r_max_b  <= r_s2_b;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_run) begin
                        r_state     <= S_RUN;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_accepted  <= '0;
                        r_err_count <= '0;
                        r_sum_ed    <= '0;
                        r_max_ed    <= '0;
                        r_max_a     <= '0;
                        r_max_b     <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_accepted <= r_accepted + CNT_W'(1);
                    end
                    if (w_last_accept) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Last sample is in stage 2 with nothing behind it: it accumulates this edge
                    if (r_s2_valid && !r_s1_valid) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Testbench for approx_mult_err_monitor: directed runs with a results scoreboard.
module tb_approx_mult_err_monitor;

    localparam int unsigned W      = 8;
    localparam int unsigned N_LOG2 = 8;
    localparam int unsigned ACC_W  = 2*W + N_LOG2;
    localparam int          RUN    = 256;

    typedef struct packed {
        logic [N_LOG2:0]  err;
        logic [ACC_W-1:0] sum;
        logic [2*W-1:0]   mx;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2*W-1:0]   in_prod;
    logic             busy;
    logic             done;
    logic [N_LOG2:0]  err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [2*W-1:0]   max_ed;
    logic [W-1:0]     max_a;
    logic [W-1:0]     max_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    logic prev_done = 1'b0;

    approx_mult_err_monitor #(.W(W), .N_LOG2(N_LOG2), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
        .busy(busy), .done(done),
        .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed),
        .max_a(max_a), .max_b(max_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compare final results on each rising edge of done
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done && !prev_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending run (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("err_count", 64'(err_count), 64'(e.err));
                chk("sum_ed",    64'(sum_ed),    64'(e.sum));
                chk("max_ed",    64'(max_ed),    64'(e.mx));
                chk("max_a",     64'(max_a),     64'(e.a));
                chk("max_b",     64'(max_b),     64'(e.b));
            end
        end
        prev_done = done;
    end

    task automatic check_cleared(input string tag);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk({tag, "_sum_ed"},    64'(sum_ed),    64'd0);
        chk({tag, "_max_ed"},    64'(max_ed),    64'd0);
        chk({tag, "_max_a"},     64'(max_a),     64'd0);
        chk({tag, "_max_b"},     64'(max_b),     64'd0);
    endtask

    // Pulse start for one cycle; returns at the negedge after the sampling edge
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one sample (optional leading bubbles); returns just after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p, input int bubble_pct, output int acc_cyc);
        int guard = 0;
        @(negedge clk);
        while (int'($urandom_range(99)) < bubble_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_a = a; in_b = b; in_prod = p; in_valid = 1'b1;
        while (!in_ready) begin
            guard++;
            if (guard > 2000) begin
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 (cycle %0d)", cyc);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (from a negedge) for done with a bounded cycle budget
    task automatic wait_done(output int done_cyc);
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        chk("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int c0, ca, cd;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_prod = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        check_cleared("rst");
        rst = 1'b0;

        // 1: exact stream, random operands, latency check
        exp_q.push_back('{err: '0, sum: '0, mx: '0, a: '0, b: '0});
        do_start();
        chk("run_in_ready", 64'(in_ready), 64'd1);
        chk("run_busy",     64'(busy),     64'd1);
        for (int i = 0; i < RUN; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send(ra, rb, 16'(ra) * 16'(rb), 0, ca);
            if (i == 0) c0 = ca;
        end
        @(negedge clk);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        chk("drain_busy",     64'(busy),     64'd1);
        wait_done(cd);
        chk("latency", 64'(cd - c0), 64'd258);
        chk("done_in_ready", 64'(in_ready), 64'd0);
        chk("done_busy",     64'(busy),     64'd0);

        // 2: zero operands with constant approximate product 6
        exp_q.push_back('{err: 9'd256, sum: 24'd1536, mx: 16'd6, a: 8'h00, b: 8'h00});
        do_start();
        for (int i = 0; i < RUN; i++) send(8'h00, 8'h00, 16'h0006, 0, ca);
        @(negedge clk);
        wait_done(cd);

        // 3: maximum error and a tie, earliest kept
        exp_q.push_back('{err: 9'd2, sum: 24'd130050, mx: 16'd65025, a: 8'hFF, b: 8'hFF});
        do_start();
        for (int i = 0; i < RUN; i++) begin
            if (i == 5 || i == 9) send(8'hFF, 8'hFF, 16'h0000, 0, ca);
            else begin
                ra = W'(i);
                rb = W'(i) ^ 8'h5A;
                send(ra, rb, 16'(ra) * 16'(rb), 0, ca);
            end
        end
        @(negedge clk);
        wait_done(cd);

        // 4: bubbles, start ignored in RUN, extra samples refused in DRAIN/DONE
        exp_q.push_back('{err: 9'd256, sum: 24'd256, mx: 16'd1, a: 8'h01, b: 8'h01});
        do_start();
        for (int i = 0; i < RUN; i++) begin
            if (i == 40) begin
                do_start();
                chk("start_ignored_busy",  64'(busy),     64'd1);
                chk("start_ignored_ready", 64'(in_ready), 64'd1);
            end
            send(8'h01, 8'h01, 16'h0000, 70, ca);
        end
        @(negedge clk);
        in_a = 8'hFF; in_b = 8'hFF; in_prod = 16'h0000; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("extra_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        chk("extra_done", 64'(done), 64'd1);
        in_valid = 1'b0;

        // 5: reset mid-run, then a fresh run
        do_start();
        for (int i = 0; i < 100; i++) send(8'hFF, 8'h01, 16'h0000, 0, ca);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_busy",     64'(busy),     64'd0);
        chk("mid_rst_done",     64'(done),     64'd0);
        check_cleared("mid_rst");
        repeat (5) @(negedge clk);
        chk("mid_rst_no_done", 64'(done), 64'd0);
        exp_q.push_back('{err: 9'd256, sum: 24'd768, mx: 16'd3, a: 8'h02, b: 8'h03});
        do_start();
        for (int i = 0; i < RUN; i++) send(8'h02, 8'h03, 16'h0003, 0, ca);
        @(negedge clk);
        wait_done(cd);

        // 6: back-to-back run from DONE, tie resolved to the earlier sample
        exp_q.push_back('{err: 9'd2, sum: 24'd512, mx: 16'd256, a: 8'h10, b: 8'h10});
        do_start();
        chk("b2b_done_low", 64'(done), 64'd0);
        chk("b2b_busy",     64'(busy), 64'd1);
        check_cleared("b2b");
        for (int i = 0; i < RUN; i++) begin
            if (i == 0) send(8'h10, 8'h10, 16'h0000, 0, ca);
            else if (i == 200) send(8'h20, 8'h08, 16'h0000, 0, ca);
            else begin
                ra = W'(i);
                send(ra, 8'h03, 16'(ra) * 16'd3, 0, ca);
            end
        end
        @(negedge clk);
        wait_done(cd);

        repeat (3) @(negedge clk);
        chk("pending_runs", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
